// File: rtl/serial_rx_if.sv
// Byte output channel of the UART receiver: data plus digit decode, valid/ready handshake.
interface serial_rx_if #(
    parameter int unsigned SERIAL_DATA_SIZE = 8
);
    logic [SERIAL_DATA_SIZE-1:0] o_data;
    logic                        o_valid;
    logic                        i_ready;
    logic [3:0]                  o_digit;
    logic                        o_is_digit;

    modport master (
        output o_data, o_valid, o_digit, o_is_digit,
        input  i_ready
    );

    modport slave (
        input  o_data, o_valid, o_digit, o_is_digit,
        output i_ready
    );
endinterface

// File: rtl/serial_rx.sv
// 8N1 UART receiver with 8x-prescaled mid-bit sampling, valid/ready byte register and ASCII digit decode.
// Optional even parity bit enabled by defining SERIAL_RX_PARITY_EN.
module serial_rx #(
    parameter int unsigned SERIAL_DATA_SIZE   = 8,
    parameter int unsigned UART_PRESCALE      = 1302,
    parameter int unsigned UART_PRESCALE_SIZE = 16
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_serial,
    serial_rx_if.master o_rx,
    output logic        o_busy,
    output logic        o_frame_error,
    output logic        o_overrun,
    output logic        o_parity_error
);
    localparam int unsigned CW = UART_PRESCALE_SIZE + 3;
    localparam int unsigned IW = (SERIAL_DATA_SIZE > 1) ? $clog2(SERIAL_DATA_SIZE) : 1;
    localparam logic [CW-1:0] BIT_M1   = CW'(8 * UART_PRESCALE - 1);
    localparam logic [CW-1:0] HALF_M1  = CW'(4 * UART_PRESCALE - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(SERIAL_DATA_SIZE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef SERIAL_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t                      r_state, w_state_next;
    logic                        r_sync1, r_rx_s;
    logic [CW-1:0]               r_cnt, w_cnt_next;
    logic [IW-1:0]               r_idx, w_idx_next;
    logic [SERIAL_DATA_SIZE-1:0] r_shift, w_shift_next;
    logic                        r_done, w_done;
    logic                        r_ferr, w_ferr;
    logic                        w_cnt_zero;
    logic [SERIAL_DATA_SIZE-1:0] r_data;
    logic                        r_valid, r_is_digit, r_overrun;
    logic [3:0]                  r_digit;
    logic                        w_is_digit;
    logic [3:0]                  w_digit;
`ifdef SERIAL_RX_PARITY_EN
    logic                        r_par_bit, w_par_next;
    logic                        r_perr, w_perr;
    logic                        w_par_bad;
    assign w_par_bad = (^r_shift) ^ r_par_bit;
`endif

    assign w_cnt_zero = (r_cnt == '0);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_done  <= 1'b0;
            r_ferr  <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            r_par_bit <= 1'b0;
            r_perr    <= 1'b0;
`endif
        end else begin
            r_sync1 <= i_serial;
            r_rx_s  <= r_sync1;
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_idx   <= w_idx_next;
            r_shift <= w_shift_next;
            r_done  <= w_done;
            r_ferr  <= w_ferr;
`ifdef SERIAL_RX_PARITY_EN
            r_par_bit <= w_par_next;
            r_perr    <= w_perr;
`endif
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_idx_next   = r_idx;
        w_shift_next = r_shift;
        w_done       = 1'b0;
        w_ferr       = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
        w_par_next   = r_par_bit;
        w_perr       = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (!r_rx_s) begin
                    w_state_next = S_START;
                    w_cnt_next   = HALF_M1;
                end
            end
            S_START: begin
                if (!w_cnt_zero) begin
                    w_cnt_next = r_cnt - 1'b1;
                end else if (r_rx_s) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_state_next = S_DATA;
                    w_cnt_next   = BIT_M1;
                    w_idx_next   = '0;
                end
            end
            S_DATA: begin
                if (!w_cnt_zero) begin
                    w_cnt_next = r_cnt - 1'b1;
                end else begin
                    w_shift_next = {r_rx_s, r_shift[SERIAL_DATA_SIZE-1:1]};
                    w_cnt_next   = BIT_M1;
                    if (r_idx == LAST_IDX) begin
`ifdef SERIAL_RX_PARITY_EN
                        w_state_next = S_PARITY;
`else
                        w_state_next = S_STOP;
`endif
                    end else begin
                        w_idx_next = r_idx + 1'b1;
                    end
                end
            end
`ifdef SERIAL_RX_PARITY_EN
            S_PARITY: begin
                if (!w_cnt_zero) begin
                    w_cnt_next = r_cnt - 1'b1;
                end else begin
                    w_par_next   = r_rx_s;
                    w_cnt_next   = BIT_M1;
                    w_state_next = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (!w_cnt_zero) begin
                    w_cnt_next = r_cnt - 1'b1;
                end else begin
`ifdef SERIAL_RX_PARITY_EN
                    w_perr = w_par_bad;
                    w_done = r_rx_s && !w_par_bad;
`else
                    w_done = r_rx_s;
`endif
                    w_ferr       = !r_rx_s;
                    w_state_next = r_rx_s ? S_IDLE : S_WAIT_HIGH;
                end
            end
            S_WAIT_HIGH: begin
                if (r_rx_s) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign w_is_digit = (r_shift >= SERIAL_DATA_SIZE'(48)) && (r_shift <= SERIAL_DATA_SIZE'(57));
    assign w_digit    = w_is_digit ? 4'(r_shift - SERIAL_DATA_SIZE'(48)) : 4'd0;

    // Completion is registered one cycle behind the stop sample, so the handshake sees a settled byte.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_digit    <= '0;
            r_is_digit <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (r_done) begin
                if (!r_valid || o_rx.i_ready) begin
                    r_data     <= r_shift;
                    r_digit    <= w_digit;
                    r_is_digit <= w_is_digit;
                    r_valid    <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && o_rx.i_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_rx.o_data     = r_data;
    assign o_rx.o_valid    = r_valid;
    assign o_rx.o_digit    = r_digit;
    assign o_rx.o_is_digit = r_is_digit;
    assign o_busy          = (r_state != S_IDLE);
    assign o_frame_error   = r_ferr;
    assign o_overrun       = r_overrun;
`ifdef SERIAL_RX_PARITY_EN
    assign o_parity_error  = r_perr;
`else
    assign o_parity_error  = 1'b0;
`endif
endmodule

// File: tb/tb_serial_rx.sv
// Directed + random frame bench for serial_rx at UART_PRESCALE=2 (16 clocks per bit).
module tb_serial_rx;
    localparam int unsigned B = 16;
`ifdef SERIAL_RX_PARITY_EN
    localparam int unsigned LAT = B / 2 + 10 * B + 3;
`else
    localparam int unsigned LAT = B / 2 + 9 * B + 3;
`endif

    logic clk = 1'b0;
    logic rst;
    logic serial;
    logic busy, ferr, ovr, perr;

    serial_rx_if #(.SERIAL_DATA_SIZE(8)) rx_if ();

    serial_rx #(
        .SERIAL_DATA_SIZE  (8),
        .UART_PRESCALE     (2),
        .UART_PRESCALE_SIZE(16)
    ) dut (
        .i_clock       (clk),
        .i_reset       (rst),
        .i_serial      (serial),
        .o_rx          (rx_if),
        .o_busy        (busy),
        .o_frame_error (ferr),
        .o_overrun     (ovr),
        .o_parity_error(perr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic [3:0] g;
        logic       isd;
        int         c;
    } rec_t;

    rec_t recs[$];
    int   checks = 0, failures = 0;
    int   cyc = 0, n_ferr = 0, n_ovr = 0, n_perr = 0, n_vhi = 0;
    logic prev_valid = 1'b0;

    function automatic logic [3:0] exp_digit(input logic [7:0] b);
        return (b >= 8'd48 && b <= 8'd57) ? 4'(b - 8'd48) : 4'd0;
    endfunction

    function automatic logic exp_isd(input logic [7:0] b);
        return (b >= 8'd48 && b <= 8'd57);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; afterwards record pulses and rising edges of o_valid.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (ferr) n_ferr++;
        if (ovr) n_ovr++;
        if (perr) n_perr++;
        if (rx_if.o_valid) n_vhi++;
        if (rx_if.o_valid && !prev_valid)
            recs.push_back('{d: rx_if.o_data, g: rx_if.o_digit, isd: rx_if.o_is_digit, c: cyc});
        prev_valid = rx_if.o_valid;
    endtask

    task automatic send_bit(input logic b, input int n);
        serial = b;
        repeat (n) tick();
    endtask

    // Returns the cycle number of the first edge that samples the start bit.
    task automatic send_frame(input logic [7:0] d, input bit par_bad, input int stop_low, output int start);
        start = cyc + 1;
        send_bit(1'b0, B);
        for (int i = 0; i < 8; i++) send_bit(d[i], B);
`ifdef SERIAL_RX_PARITY_EN
        send_bit((^d) ^ par_bad, B);
`else
        if (par_bad) $display("note: parity request ignored in this build");
`endif
        if (stop_low > 0) begin
            send_bit(1'b0, stop_low);
            serial = 1'b1;
        end else begin
            send_bit(1'b1, B);
        end
    endtask

    initial begin
        int st, base, f0, o0, p0;
        logic [7:0] exp_q[$];
        logic [7:0] b;

        rst = 1'b1;
        serial = 1'b1;
        rx_if.i_ready = 1'b1;
        repeat (3) tick();
        chk("reset_valid", rx_if.o_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_data", rx_if.o_data, 0);
        chk("reset_pulses", {ferr, ovr, perr}, 0);
        rst = 1'b0;
        repeat (5) tick();

        // Single frame, latency and one-cycle valid
        base = recs.size();
        n_vhi = 0;
        send_frame(8'h35, 1'b0, 0, st);
        repeat (10) tick();
        chk("f35_count", recs.size() - base, 1);
        if (recs.size() > base) begin
            chk("f35_latency", recs[base].c - st, LAT);
            chk("f35_data", recs[base].d, 8'h35);
            chk("f35_digit", recs[base].g, 5);
            chk("f35_isdig", recs[base].isd, 1);
        end
        chk("f35_valid_cycles", n_vhi, 1);

        // Held byte and overrun
        rx_if.i_ready = 1'b0;
        send_frame(8'h41, 1'b0, 0, st);
        repeat (10) tick();
        chk("f41_valid", rx_if.o_valid, 1);
        chk("f41_data", rx_if.o_data, 8'h41);
        chk("f41_isdig", rx_if.o_is_digit, 0);
        chk("f41_digit", rx_if.o_digit, 0);
        o0 = n_ovr;
        send_frame(8'h39, 1'b0, 0, st);
        repeat (10) tick();
        chk("ovr_pulse", n_ovr - o0, 1);
        chk("ovr_data_kept", rx_if.o_data, 8'h41);
        rx_if.i_ready = 1'b1;
        tick();
        chk("ready_clears_valid", rx_if.o_valid, 0);

        // Frame error with long low stop, then recovery
        base = recs.size();
        f0 = n_ferr;
        send_frame(8'h30, 1'b0, 40, st);
        chk("ferr_busy_low_line", busy, 1);
        repeat (5) tick();
        chk("ferr_busy_after_rise", busy, 0);
        chk("ferr_pulse", n_ferr - f0, 1);
        chk("ferr_no_byte", recs.size() - base, 0);
        send_frame(8'h31, 1'b0, 0, st);
        repeat (10) tick();
        chk("f31_count", recs.size() - base, 1);
        if (recs.size() > base) chk("f31_data", recs[base].d, 8'h31);

        // Glitch on idle line
        base = recs.size();
        f0 = n_ferr;
        o0 = n_ovr;
        send_bit(1'b0, 4);
        send_bit(1'b1, 30);
        chk("glitch_idle", busy, 0);
        chk("glitch_no_byte", recs.size() - base, 0);
        chk("glitch_no_pulse", (n_ferr - f0) + (n_ovr - o0), 0);

        // Reset mid-data
        send_bit(1'b0, B);
        for (int i = 0; i < 3; i++) send_bit(b_of(8'h37, i), B);
        rst = 1'b1;
        tick();
        chk("midreset_busy", busy, 0);
        chk("midreset_valid", rx_if.o_valid, 0);
        rst = 1'b0;
        serial = 1'b1;
        repeat (20) tick();
        chk("midreset_idle", busy, 0);
        base = recs.size();
        send_frame(8'h38, 1'b0, 0, st);
        repeat (10) tick();
        chk("f38_count", recs.size() - base, 1);
        if (recs.size() > base) chk("f38_digit", recs[base].g, 8);

        // Back-to-back ASCII digits followed by random bytes, no idle gap
        base = recs.size();
        for (int i = 0; i < 10; i++) exp_q.push_back(8'(48 + i));
        for (int i = 0; i < 6; i++) exp_q.push_back(8'($urandom_range(0, 255)));
        foreach (exp_q[i]) send_frame(exp_q[i], 1'b0, 0, st);
        repeat (10) tick();
        chk("b2b_count", recs.size() - base, exp_q.size());
        foreach (exp_q[i]) begin
            if (base + i < recs.size()) begin
                b = exp_q[i];
                chk($sformatf("b2b_data_%0d", i), recs[base + i].d, b);
                chk($sformatf("b2b_digit_%0d", i), {recs[base + i].isd, recs[base + i].g}, {exp_isd(b), exp_digit(b)});
            end
        end

`ifdef SERIAL_RX_PARITY_EN
        base = recs.size();
        p0 = n_perr;
        send_frame(8'h33, 1'b0, 0, st);
        repeat (10) tick();
        chk("par_ok_count", recs.size() - base, 1);
        chk("par_ok_no_err", n_perr - p0, 0);
        base = recs.size();
        send_frame(8'h33, 1'b1, 0, st);
        repeat (10) tick();
        chk("par_bad_pulse", n_perr - p0, 1);
        chk("par_bad_no_byte", recs.size() - base, 0);
        chk("par_bad_valid", rx_if.o_valid, 0);
`else
        p0 = n_perr;
        repeat (2) tick();
        chk("par_tied_low", n_perr - p0, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    function automatic logic b_of(input logic [7:0] d, input int i);
        return d[i];
    endfunction
endmodule

// File: doc/serial_rx.md
Name: serial_rx

Overview:
- UART receiver: the receive end of the 8N1 serial link the board's serial transmitter drives (9600 baud, LSB first).
- Oversamples i_serial and recovers bytes. Presents each byte on a valid/ready output register and decodes ASCII digits '0'..'9' (48..57) to binary 0..9.
- Self-contained; no external UART core. Sits between the board RX pin and the consumer logic.

Parameters:
- SERIAL_DATA_SIZE, 8, data bits per frame.
- UART_PRESCALE, 1302, bit period in clocks divided by 8. BIT_CYCLES = 8*UART_PRESCALE (10416 = 9600 baud at 100 MHz).
- UART_PRESCALE_SIZE, 16, width of prescale arithmetic; bit counter is UART_PRESCALE_SIZE+3 bits.

Ports:
- i_clock  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_serial  in  1  asynchronous RX line, idle high.
- i_ready  in  1  consumer accepts o_data when high with o_valid.
- o_data  out  SERIAL_DATA_SIZE  last received byte.
- o_valid  out  1  o_data holds an unaccepted byte.
- o_digit  out  4  o_data-48 when o_is_digit, else 0.
- o_is_digit  out  1  o_data in 48..57.
- o_busy  out  1  FSM not IDLE.
- o_frame_error  out  1  1-cycle pulse: stop bit sampled low.
- o_overrun  out  1  1-cycle pulse: byte dropped because the output register was full.
- o_parity_error  out  1  1-cycle pulse; see Optional Feature.

Behaviour:
- Reset, taken on the clock edge while i_reset is high:
  - Synchronizer flops reset to 1, so there is no false start after reset.
  - FSM goes to IDLE; counters, shift register and all outputs reset to 0.
  - A frame in progress is abandoned silently.
- Input sync: 2-flop synchronizer; the FSM uses only the synchronized value rx_s.
- FSM states are IDLE, START, DATA, [PARITY], STOP, WAIT_HIGH.
  - IDLE: on rx_s == 0, go to START and load cnt = BIT_CYCLES/2 - 1.
  - START: decrement cnt. At cnt == 0, sample rx_s.
    - If rx_s == 1 (glitch), go to IDLE with no pulse.
    - If rx_s == 0, go to DATA with cnt = BIT_CYCLES-1 and bit index 0.
  - DATA: at each cnt == 0, shift rx_s in LSB-first and reload cnt. After bit SERIAL_DATA_SIZE-1, go to PARITY if enabled, else STOP.
  - STOP: at cnt == 0, sample rx_s.
    - If rx_s == 1: complete the byte and go to IDLE. The next start edge is accepted immediately.
    - If rx_s == 0: pulse o_frame_error, discard the byte, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s == 1, then go to IDLE.
- o_busy = (state != IDLE).
- Output register, evaluated on the byte-complete cycle:
  - If o_valid == 0, or i_ready == 1 in the same cycle: load o_data, o_digit and o_is_digit; o_valid goes to 1 on the next edge.
  - Otherwise: keep the old byte and pulse o_overrun.
  - Without a completion, o_valid && i_ready clears o_valid on the next edge. o_data holds its value.
- Latency: o_valid rises BIT_CYCLES/2 + (SERIAL_DATA_SIZE+1)*BIT_CYCLES + 3 clocks after the first clock on which i_serial is sampled low. The 3 clocks are 2 for synchronization and 1 for the output register. Add BIT_CYCLES when parity is enabled.
- Digit decode: o_is_digit = (byte >= 48 && byte <= 57); o_digit = byte - 48 (4 LSBs), else 0. Both are registered with o_data.
- Back-to-back frames with zero idle time between the stop bit and the next start bit are received without loss.

Optional Feature:
- Macro: SERIAL_RX_PARITY_EN.
- Defined: an even-parity bit follows the data bits. The PARITY state samples it at its midpoint.
  - Expected parity = XOR of the data bits.
  - On mismatch, o_parity_error pulses when the stop bit is sampled. The byte is discarded, not loaded and not counted as overrun.
  - A frame error takes precedence; both pulses may assert together.
- Not defined: no PARITY state; o_parity_error is tied to 0.

Test Plan:
- UART_PRESCALE=2 (BIT_CYCLES=16), i_ready=1, send 8N1 frame 0x35 -> o_valid high for 1 cycle at 155 clocks after the start edge (8+144+3); o_data=0x35, o_digit=5, o_is_digit=1.
- Send 0x41, i_ready=0 -> o_valid stays 1, o_is_digit=0, o_digit=0. Send 0x39 before any ready -> o_overrun pulses once, o_data stays 0x41. Raise i_ready -> o_valid=0 next cycle.
- Frame 0x30 with stop bit held low for 40 clocks -> o_frame_error pulses once, o_valid stays 0, o_busy stays 1 until the line rises. The next frame 0x31 is received correctly.
- 4-clock low glitch on idle line -> returns to IDLE at the half-bit check; no pulses, o_valid stays 0.
- Assert i_reset mid-DATA of frame 0x37 -> o_busy=0 and o_valid=0 after the edge. The next frame 0x38 yields o_digit=8. Back-to-back frames 0x30 to 0x39 with no idle gap give 10 valid bytes in order.
- With SERIAL_RX_PARITY_EN: 0x33 with correct parity (0) -> accepted. 0x33 with parity bit 1 -> o_parity_error pulses, o_valid stays 0.
